// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode and ModRM constants for the supported x86 subset,
// plus the fetch state encoding and instruction length limits.
package cpu_pkg;

  localparam logic [7:0] OP_PUSH_EBP   = 8'h55;
  localparam logic [7:0] OP_PUSH_EBX   = 8'h53;
  localparam logic [7:0] OP_POP_EBP    = 8'h5d;
  localparam logic [7:0] OP_MOV_RM_ST  = 8'h89;
  localparam logic [7:0] OP_PUSH_IMM8  = 8'h6a;
  localparam logic [7:0] OP_MOV_RM_LD  = 8'h8b;
  localparam logic [7:0] OP_MOV_EAX_I  = 8'hb8;
  localparam logic [7:0] OP_CALL_REL   = 8'he8;
  localparam logic [7:0] OP_GRP1_IMM8  = 8'h83;
  localparam logic [7:0] OP_RET        = 8'hc3;
  localparam logic [7:0] OP_LEAVE      = 8'hc9;

  localparam logic [7:0] MODRM_EBP_DISP8 = 8'h7d;
  localparam logic [7:0] MODRM_SUB_ESP   = 8'hec;
  localparam logic [7:0] MODRM_ADD_ESP   = 8'hc4;
  localparam logic [7:0] MODRM_SUB_EAX   = 8'he8;

  localparam int MAX_LEN = 5;
  localparam int LEN_W   = 4;

  typedef enum logic [1:0] {
    FETCH_ISSUE   = 2'd0,
    FETCH_COLLECT = 2'd1,
    FETCH_HOLD    = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/insn_len_decode.sv
// Combinational instruction length decoder: byte0 selects the length, byte1 only
// matters for the 83 group where a [ebp+disp8] ModRM adds one displacement byte.
module insn_len_decode
  import cpu_pkg::*;
(
  input  logic [7:0]       byte0,
  input  logic [7:0]       byte1,
  output logic [LEN_W-1:0] len,
  output logic             illegal
);

  // length lookup; unknown opcodes are consumed as single illegal bytes
  always_comb begin
    len     = 4'd1;
    illegal = 1'b0;
    case (byte0)
      OP_PUSH_EBP, OP_PUSH_EBX, OP_POP_EBP, OP_RET, OP_LEAVE: len = 4'd1;
      OP_MOV_RM_ST, OP_PUSH_IMM8:                             len = 4'd2;
      OP_MOV_RM_LD:                                           len = 4'd3;
      OP_MOV_EAX_I, OP_CALL_REL:                              len = 4'd5;
      OP_GRP1_IMM8: begin
        if (byte1 == MODRM_EBP_DISP8) len = 4'd4;
        else                          len = 4'd3;
      end
      default: begin
        len     = 4'd1;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/insn_fetch.sv
// Byte-serial instruction fetch: issues pipelined byte reads, assembles one
// variable-length instruction and holds it until the ALU accepts it.
module insn_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_rd,
  output logic [31:0]       mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_addr,
  output logic [31:0]       ope,
  output logic [7:0]        ope_ext,
  output logic [LEN_W-1:0]  num_of_ope,
  output logic [31:0]       ope_pc,
  output logic              illegal,
  output logic              ope_valid,
  input  logic              ope_ready
);

  localparam logic [1:0] ST_ISSUE   = FETCH_ISSUE;
  localparam logic [1:0] ST_COLLECT = FETCH_COLLECT;
  localparam logic [1:0] ST_HOLD    = FETCH_HOLD;

  logic [1:0]       state_r;
  logic [31:0]      pc_r;
  logic [2:0]       cnt_r;
  logic [31:0]      buf_r;
  logic [31:0]      ope_r;
  logic [7:0]       ope_ext_r;
  logic [LEN_W-1:0] num_r;
  logic [31:0]      ope_pc_r;
  logic             illegal_r;
  logic             ope_valid_r;

  logic [7:0]       byte0_s;
  logic [7:0]       byte1_s;
  logic [LEN_W-1:0] len_s;
  logic             illegal_s;
  logic             last_s;
  logic             fire_s;
  logic [31:0]      asm_s;

  insn_len_decode u_len_decode (
    .byte0   (byte0_s),
    .byte1   (byte1_s),
    .len     (len_s),
    .illegal (illegal_s)
  );

  // byte arriving this cycle is fed straight to the decoder so the next read can issue at once
  always_comb begin
    if (cnt_r == 3'd0) byte0_s = mem_rdata;
    else               byte0_s = buf_r[31:24];
    if (cnt_r == 3'd1) byte1_s = mem_rdata;
    else               byte1_s = buf_r[23:16];
    last_s = (({1'b0, cnt_r} + 4'd1) >= len_s);
    fire_s = ope_valid_r & ope_ready;
    case (cnt_r)
      3'd0:    asm_s = {mem_rdata, 24'h000000};
      3'd1:    asm_s = {buf_r[31:24], mem_rdata, 16'h0000};
      3'd2:    asm_s = {buf_r[31:16], mem_rdata, 8'h00};
      3'd3:    asm_s = {buf_r[31:8], mem_rdata};
      default: asm_s = buf_r;
    endcase
  end

  // read strobe; a redirect suppresses the read since its data would be dropped anyway
  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = pc_r;
    if (reset || redirect_valid) begin
      mem_rd   = 1'b0;
      mem_addr = pc_r;
    end else begin
      case (state_r)
        ST_ISSUE: begin
          mem_rd   = 1'b1;
          mem_addr = pc_r;
        end
        ST_COLLECT: begin
          mem_rd   = ~last_s;
          mem_addr = pc_r + {29'd0, cnt_r} + 32'd1;
        end
        default: begin
          mem_rd   = 1'b0;
          mem_addr = pc_r;
        end
      endcase
    end
  end

  // fetch sequencing, assembly buffer and registered instruction outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_ISSUE;
      pc_r        <= RESET_PC;
      cnt_r       <= 3'd0;
      buf_r       <= 32'h0;
      ope_r       <= 32'h0;
      ope_ext_r   <= 8'h00;
      num_r       <= 4'd0;
      ope_pc_r    <= 32'h0;
      illegal_r   <= 1'b0;
      ope_valid_r <= 1'b0;
    end else if (redirect_valid) begin
      // a transfer in this cycle still completes downstream; only the next fetch moves
      state_r     <= ST_ISSUE;
      pc_r        <= redirect_addr;
      cnt_r       <= 3'd0;
      ope_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ISSUE: begin
          state_r <= ST_COLLECT;
          cnt_r   <= 3'd0;
        end
        ST_COLLECT: begin
          buf_r <= asm_s;
          if (last_s) begin
            ope_r       <= asm_s;
            ope_ext_r   <= (cnt_r == 3'd4) ? mem_rdata : 8'h00;
            num_r       <= len_s;
            illegal_r   <= illegal_s;
            ope_pc_r    <= pc_r;
            ope_valid_r <= 1'b1;
            state_r     <= ST_HOLD;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        ST_HOLD: begin
          if (fire_s) begin
            pc_r        <= pc_r + {28'd0, num_r};
            ope_valid_r <= 1'b0;
            state_r     <= ST_ISSUE;
          end else begin
            ope_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_ISSUE;
          ope_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ope        = ope_r;
  assign ope_ext    = ope_ext_r;
  assign num_of_ope = num_r;
  assign ope_pc     = ope_pc_r;
  assign illegal    = illegal_r;
  assign ope_valid  = ope_valid_r;

endmodule
